// File: rtl/cby_param_shadow_ccff.sv
// -----------------------------------------------------------------------------
// cby_param_shadow_ccff
//
// Connection block Y. The vertical channel passes straight through this block.
// NUM_IPIN programmable muxes tap the channel and drive the grid input pins.
//
// The routing configuration arrives on the ccff scan chain and is double
// buffered. Shifting fills a shadow register and never changes the live
// routing. A commit copies the shadow register into the active register in a
// single edge, so the fabric can keep running while it is reprogrammed.
//
// A commit is accepted only when exactly TOTAL bits were shifted since the
// last commit or reset. A rejected commit leaves the routing as it was and
// raises cfg_err.
//
// Ports
//   prog_clk          configuration clock
//   pReset            asynchronous reset, active low
//   chany_bottom_in   tracks entering from below        [CHAN_W]
//   chany_top_in      tracks entering from above        [CHAN_W]
//   chany_bottom_out  tracks leaving downward (= top_in)    [CHAN_W]
//   chany_top_out     tracks leaving upward (= bottom_in)  [CHAN_W]
//   ccff_head         serial configuration data in
//   ccff_shift_en     shift the chain this cycle
//   ccff_commit       request a shadow-to-active transfer
//   ccff_tail         serial configuration data out, to the next block
//   ipin_out          mux outputs to the grid pins      [NUM_IPIN]
//   cfg_count         bits shifted since the last commit or reset [CNT_W]
//   cfg_valid         an active configuration is loaded
//   cfg_err           the last commit was rejected
// -----------------------------------------------------------------------------
module cby_param_shadow_ccff #(
   parameter  int unsigned CHAN_W   = 11,
   parameter  int unsigned NUM_IPIN = 8,
   parameter  int unsigned TAPS     = 3,
   parameter  int unsigned STRIDE   = 5,
   localparam int unsigned M        = 2 * TAPS,
   localparam int unsigned SEL_W    = (M > 1) ? $clog2(M) : 1,
   localparam int unsigned TOTAL    = NUM_IPIN * SEL_W,
   localparam int unsigned CNT_W    = $clog2(TOTAL + 2)
) (
   input  logic                prog_clk,
   input  logic                pReset,
   input  logic [CHAN_W-1:0]   chany_bottom_in,
   input  logic [CHAN_W-1:0]   chany_top_in,
   output logic [CHAN_W-1:0]   chany_bottom_out,
   output logic [CHAN_W-1:0]   chany_top_out,
   input  logic                ccff_head,
   input  logic                ccff_shift_en,
   input  logic                ccff_commit,
   output logic                ccff_tail,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic [CNT_W-1:0]    cfg_count,
   output logic                cfg_valid,
   output logic                cfg_err
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL + 1);

   logic [TOTAL-1:0] r_shadow;
   logic [TOTAL-1:0] r_active;
   logic [CNT_W-1:0] r_count;
   logic             r_valid;
   logic             r_err;

   logic             w_commit_ok;
   logic [CNT_W-1:0] w_count_next;

   // ---------------------------------------------------------------------------
   // Channel pass-through
   // ---------------------------------------------------------------------------
   assign chany_top_out    = chany_bottom_in;
   assign chany_bottom_out = chany_top_in;

   // ---------------------------------------------------------------------------
   // Commit check and bit counter
   // ---------------------------------------------------------------------------
   // The commit decision uses the count held before this edge. A shift on the
   // same edge therefore cannot turn a bad commit into a good one.
   assign w_commit_ok = ccff_commit && (r_count == CNT_FULL);

   always_comb begin
      w_count_next = r_count;
      if (ccff_commit) begin
         // The commit clears the count. A shift on the same edge is the
         // first bit of the next load.
         w_count_next = ccff_shift_en ? CNT_W'(1) : '0;
      end else if (ccff_shift_en && (r_count != CNT_SAT)) begin
         w_count_next = r_count + CNT_W'(1);
      end
   end

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Shadow chain
   // ---------------------------------------------------------------------------
   // This loop form also works for TOTAL == 1, where a concatenation shift
   // would need an empty slice.
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         r_shadow <= '0;
      end else if (ccff_shift_en) begin
         r_shadow[0] <= ccff_head;
         for (int unsigned k = 1; k < TOTAL; k++) begin
            r_shadow[k] <= r_shadow[k-1];
         end
      end
   end

   // The tail comes straight from a flop, so the chain moves one bit per cycle.
   assign ccff_tail = r_shadow[TOTAL-1];

   // ---------------------------------------------------------------------------
   // Active configuration and status
   // ---------------------------------------------------------------------------
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         r_active <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else if (ccff_commit) begin
         if (w_commit_ok) begin
            r_active <= r_shadow;
            r_valid  <= 1'b1;
            r_err    <= 1'b0;
         end else begin
            r_err    <= 1'b1;
         end
      end
   end

   assign cfg_count = r_count;
   assign cfg_valid = r_valid;
   assign cfg_err   = r_err;

   // ---------------------------------------------------------------------------
   // Input-pin muxes
   // ---------------------------------------------------------------------------
   // Each pin has a tap vector padded to 2**SEL_W entries. A select value of M
   // or more lands on a constant-zero entry, so an out-of-range select needs
   // no separate compare.
   for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
      logic [(1<<SEL_W)-1:0] w_taps;
      logic [SEL_W-1:0]      w_sel;

      assign w_sel = r_active[gi*SEL_W +: SEL_W];

      for (genvar gk = 0; gk < (1 << SEL_W); gk++) begin : g_tap
         if (gk < M) begin : g_live
            localparam int unsigned T = (gi + (gk / 2) * STRIDE) % CHAN_W;
            if ((gk % 2) == 1) begin : g_top
               assign w_taps[gk] = chany_top_in[T];
            end else begin : g_bot
               assign w_taps[gk] = chany_bottom_in[T];
            end
         end else begin : g_dead
            assign w_taps[gk] = 1'b0;
         end
      end

      assign ipin_out[gi] = r_valid & w_taps[w_sel];
   end

endmodule

// File: tb/tb_cby_param_shadow_ccff.sv
module tb_cby_param_shadow_ccff;

   localparam int CHAN_W   = 11;
   localparam int NUM_IPIN = 8;
   localparam int TAPS     = 3;
   localparam int STRIDE   = 5;
   localparam int M        = 2 * TAPS;
   localparam int SEL_W    = 3;
   localparam int TOTAL    = NUM_IPIN * SEL_W;
   localparam int CNT_W    = 5;

   logic                prog_clk;
   logic                pReset;
   logic [CHAN_W-1:0]   chany_bottom_in;
   logic [CHAN_W-1:0]   chany_top_in;
   logic [CHAN_W-1:0]   chany_bottom_out;
   logic [CHAN_W-1:0]   chany_top_out;
   logic                ccff_head;
   logic                ccff_shift_en;
   logic                ccff_commit;
   logic                ccff_tail;
   logic [NUM_IPIN-1:0] ipin_out;
   logic [CNT_W-1:0]    cfg_count;
   logic                cfg_valid;
   logic                cfg_err;

   cby_param_shadow_ccff #(
      .CHAN_W  (CHAN_W),
      .NUM_IPIN(NUM_IPIN),
      .TAPS    (TAPS),
      .STRIDE  (STRIDE)
   ) dut (
      .prog_clk        (prog_clk),
      .pReset          (pReset),
      .chany_bottom_in (chany_bottom_in),
      .chany_top_in    (chany_top_in),
      .chany_bottom_out(chany_bottom_out),
      .chany_top_out   (chany_top_out),
      .ccff_head       (ccff_head),
      .ccff_shift_en   (ccff_shift_en),
      .ccff_commit     (ccff_commit),
      .ccff_tail       (ccff_tail),
      .ipin_out        (ipin_out),
      .cfg_count       (cfg_count),
      .cfg_valid       (cfg_valid),
      .cfg_err         (cfg_err)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // Observed bundle: {ipin_out, ccff_tail, cfg_count, cfg_valid, cfg_err}
   logic [15:0] w_obs;
   assign w_obs = {ipin_out, ccff_tail, cfg_count, cfg_valid, cfg_err};

   // Reference model state
   logic [TOTAL-1:0] m_s;
   logic [TOTAL-1:0] m_a;
   int               m_cnt;
   logic             m_valid;
   logic             m_err;

   typedef struct {
      string       tag;
      logic [15:0] v;
   } sb_t;
   sb_t sb[$];

   int n_checks = 0;
   int n_errors = 0;

   function automatic void model_reset();
      m_s = '0; m_a = '0; m_cnt = 0; m_valid = 1'b0; m_err = 1'b0;
   endfunction

   function automatic logic [NUM_IPIN-1:0] model_ipin();
      logic [NUM_IPIN-1:0] r;
      int sel;
      int t;
      r = '0;
      if (m_valid) begin
         for (int i = 0; i < NUM_IPIN; i++) begin
            sel = int'(m_a[i*SEL_W +: SEL_W]);
            if (sel < M) begin
               t = (i + (sel / 2) * STRIDE) % CHAN_W;
               r[i] = (sel % 2 == 1) ? chany_top_in[t] : chany_bottom_in[t];
            end
         end
      end
      return r;
   endfunction

   function automatic void sb_push(input string tag);
      sb_t e;
      e.tag = tag;
      e.v   = {model_ipin(), m_s[TOTAL-1], 5'(m_cnt), m_valid, m_err};
      sb.push_back(e);
   endfunction

   function automatic logic [TOTAL-1:0] mk_cfg(input int pin, input logic [2:0] sel,
                                              input logic [2:0] others);
      logic [TOTAL-1:0] c;
      for (int i = 0; i < NUM_IPIN; i++) c[i*SEL_W +: SEL_W] = (i == pin) ? sel : others;
      return c;
   endfunction

   // One configuration clock with the given controls. The model is updated
   // with the values held before the edge.
   task automatic step(input logic head, input logic sh, input logic cm);
      ccff_head = head; ccff_shift_en = sh; ccff_commit = cm;
      @(posedge prog_clk);
      if (cm) begin
         if (m_cnt == TOTAL) begin
            m_a = m_s; m_valid = 1'b1; m_err = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end
      if (sh) m_s = {m_s[TOTAL-2:0], head};
      if (cm) m_cnt = sh ? 1 : 0;
      else if (sh && m_cnt < TOTAL + 1) m_cnt++;
      #1;
      ccff_head = 1'b0; ccff_shift_en = 1'b0; ccff_commit = 1'b0;
   endtask

   task automatic load_cfg(input logic [TOTAL-1:0] cfg);
      for (int b = TOTAL - 1; b >= 0; b--) step(cfg[b], 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic set_chan(input logic [CHAN_W-1:0] bot, input logic [CHAN_W-1:0] top);
      chany_bottom_in = bot; chany_top_in = top;
      #1;
   endtask

   task automatic test_reset();
      sb_t e;
      pReset = 1'b0;
      set_chan(CHAN_W'($urandom()), CHAN_W'($urandom()));
      ccff_head = 1'b1; ccff_shift_en = 1'b1; ccff_commit = 1'b1;
      repeat (3) @(posedge prog_clk);
      #1;
      model_reset();
      sb_push("reset_hold");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      n_checks++;
      if (chany_top_out !== chany_bottom_in || chany_bottom_out !== chany_top_in) begin
         n_errors++;
         $display("FAIL passthru_reset: top_out=%h bot_out=%h expected %h %h",
                  chany_top_out, chany_bottom_out, chany_bottom_in, chany_top_in);
      end
      ccff_head = 1'b0; ccff_shift_en = 1'b0; ccff_commit = 1'b0;
      pReset = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      sb_push("reset_release");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      set_chan(CHAN_W'($urandom()), CHAN_W'($urandom()));
      n_checks++;
      if (chany_top_out !== chany_bottom_in || chany_bottom_out !== chany_top_in) begin
         n_errors++;
         $display("FAIL passthru_run: top_out=%h bot_out=%h expected %h %h",
                  chany_top_out, chany_bottom_out, chany_bottom_in, chany_top_in);
      end
   endtask

   task automatic test_load();
      sb_t e;
      logic [CHAN_W-1:0] bots[6];
      logic [CHAN_W-1:0] tops[6];
      set_chan('0, '0);
      load_cfg(mk_cfg(0, 3'd2, 3'd0));
      sb_push("load_commit");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      n_checks++;
      if (cfg_valid !== 1'b1 || cfg_err !== 1'b0 || cfg_count !== 5'd0) begin
         n_errors++;
         $display("FAIL load_status: valid=%b err=%b count=%0d expected 1 0 0", cfg_valid, cfg_err, cfg_count);
      end
      set_chan(11'h020, '0);
      n_checks++;
      if (ipin_out[0] !== 1'b1) begin
         n_errors++; $display("FAIL pin0_track5: got=%b expected=1", ipin_out[0]);
      end
      bots = '{11'h001, '1, '0, CHAN_W'($urandom()), CHAN_W'($urandom()), CHAN_W'($urandom())};
      tops = '{'0, '0, '1, CHAN_W'($urandom()), CHAN_W'($urandom()), CHAN_W'($urandom())};
      for (int p = 0; p < 6; p++) begin
         set_chan(bots[p], tops[p]);
         sb_push($sformatf("load_pattern%0d", p));
         e = sb.pop_front(); n_checks++;
         if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      end
   endtask

   task automatic test_short_load();
      sb_t e;
      for (int b = 0; b < TOTAL - 1; b++) step(1'($urandom()), 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      sb_push("short_commit");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      n_checks++;
      if (cfg_err !== 1'b1 || cfg_valid !== 1'b1) begin
         n_errors++; $display("FAIL short_status: err=%b valid=%b expected 1 1", cfg_err, cfg_valid);
      end
      load_cfg(TOTAL'($urandom()));
      for (int p = 0; p < 3; p++) begin
         set_chan(CHAN_W'($urandom()), CHAN_W'($urandom()));
         sb_push($sformatf("full_reload%0d", p));
         e = sb.pop_front(); n_checks++;
         if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      end
   endtask

   task automatic test_overshift();
      sb_t e;
      for (int b = 0; b < TOTAL + 3; b++) step(1'($urandom()), 1'b1, 1'b0);
      sb_push("overshift_sat");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      step(1'b0, 1'b0, 1'b1);
      sb_push("overshift_commit");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
   endtask

   task automatic test_invalid_sel();
      sb_t e;
      load_cfg(mk_cfg(3, 3'd7, 3'd1));
      for (int p = 0; p < 5; p++) begin
         if (p == 0) set_chan('1, '1);
         else set_chan(CHAN_W'($urandom()), CHAN_W'($urandom()));
         sb_push($sformatf("sel7_pattern%0d", p));
         e = sb.pop_front(); n_checks++;
         if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
         n_checks++;
         if (ipin_out[3] !== 1'b0) begin n_errors++; $display("FAIL sel7_pin3: got=%b expected=0", ipin_out[3]); end
      end
      load_cfg(mk_cfg(3, 3'd1, 3'd0));
      for (int p = 0; p < 4; p++) begin
         set_chan(CHAN_W'($urandom()), CHAN_W'(p[0] ? 11'h008 : 11'h7f7));
         n_checks++;
         if (ipin_out[3] !== chany_top_in[3]) begin
            n_errors++; $display("FAIL sel1_pin3: got=%b expected=%b", ipin_out[3], chany_top_in[3]);
         end
      end
   endtask

   task automatic test_chain();
      sb_t e;
      set_chan(CHAN_W'($urandom()), CHAN_W'($urandom()));
      for (int b = 0; b < TOTAL; b++) begin
         step((b == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
         sb_push($sformatf("chain_shift%0d", b + 1));
         e = sb.pop_front(); n_checks++;
         if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      end
      n_checks++;
      if (ccff_tail !== 1'b1) begin n_errors++; $display("FAIL chain_tail24: got=%b expected=1", ccff_tail); end
      step(1'b0, 1'b0, 1'b1);
      for (int p = 0; p < 3; p++) begin
         set_chan(CHAN_W'($urandom()), CHAN_W'($urandom()));
         sb_push($sformatf("chain_commit%0d", p));
         e = sb.pop_front(); n_checks++;
         if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      end
   endtask

   task automatic test_shift_commit();
      sb_t e;
      for (int b = 0; b < TOTAL; b++) step(1'($urandom()), 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      set_chan(CHAN_W'($urandom()), CHAN_W'($urandom()));
      sb_push("shift_commit");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      n_checks++;
      if (cfg_count !== 5'd1 || cfg_err !== 1'b0) begin
         n_errors++; $display("FAIL shift_commit_count: count=%0d err=%b expected 1 0", cfg_count, cfg_err);
      end
   endtask

   task automatic test_async_reset();
      sb_t e;
      for (int b = 0; b < 10; b++) step(1'b1, 1'b1, 1'b0);
      #2;
      pReset = 1'b0;
      #1;
      model_reset();
      sb_push("async_reset");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      @(posedge prog_clk);
      #1;
      pReset = 1'b1;
      step(1'b0, 1'b0, 1'b1);
      sb_push("commit_after_reset");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
      load_cfg(TOTAL'($urandom()));
      set_chan(CHAN_W'($urandom()), CHAN_W'($urandom()));
      sb_push("reload_after_reset");
      e = sb.pop_front(); n_checks++;
      if (w_obs !== e.v) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.tag, w_obs, e.v); end
   endtask

   initial begin
      pReset = 1'b0;
      chany_bottom_in = '0; chany_top_in = '0;
      ccff_head = 1'b0; ccff_shift_en = 1'b0; ccff_commit = 1'b0;
      model_reset();
      #2;
      test_reset();
      test_load();
      test_short_load();
      test_overshift();
      test_invalid_sel();
      test_chain();
      test_shift_commit();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1);
   end

endmodule
